// File: rtl/ddr_cio_pkg.sv
// Shared types and burst geometry for the common-I/O burst-of-4 DDR SRAM sequencer.
// Beat packing is LSB-first: beat i of a burst occupies bits [i*W +: W].
package ddr_cio_pkg;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_GAP  = 2'd2
   } ctrl_state_e;

   localparam int BURST_LEN       = 4;
   localparam int BEATS_PER_PAIR  = 2;
   localparam int PAIRS_PER_BURST = BURST_LEN / BEATS_PER_PAIR;

   // Bit offset of a beat inside a packed burst vector.
   function automatic int beat_lsb(input int beat, input int width);
      return beat * width;
   endfunction

endpackage

// File: rtl/ddr_cio_b4_ctrl_if.sv
// Host-side burst request/response bundle of the DDR burst-of-4 sequencer.
interface ddr_cio_b4_ctrl_if
   import ddr_cio_pkg::*;
#(
   parameter int ADDR_BITS = 20,
   parameter int DATA_BITS = 8,
   parameter int BWN       = 2
);
   logic                           req_valid;
   logic                           req_ready;
   logic                           req_rd;
   logic [ADDR_BITS-1:0]           req_addr;
   logic [BURST_LEN*DATA_BITS-1:0] req_wdata;
   logic [BURST_LEN*BWN-1:0]       req_nw_b;
   logic                           rsp_valid;
   logic [BURST_LEN*DATA_BITS-1:0] rsp_data;

   modport master (
      output req_valid, req_rd, req_addr, req_wdata, req_nw_b,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_rd, req_addr, req_wdata, req_nw_b,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/ddr_cio_rd_asm.sv
// Collects two captured rise/fall pairs into one 4-beat read burst and pulses rsp_valid.
// Pairs arrive strictly in order, so a single toggle bit tells first from second.
module ddr_cio_rd_asm
   import ddr_cio_pkg::*;
#(
   parameter int DATA_BITS = 8
) (
   input  logic                           K,
   input  logic                           RST_b,
   input  logic                           rd_pair_valid,
   input  logic [DATA_BITS-1:0]           rd_r,
   input  logic [DATA_BITS-1:0]           rd_f,
   output logic                           rsp_valid,
   output logic [BURST_LEN*DATA_BITS-1:0] rsp_data
);

   logic                                pair_tog_r;
   logic [BEATS_PER_PAIR*DATA_BITS-1:0] lo_pair_r;
   logic                                rsp_valid_r;
   logic [BURST_LEN*DATA_BITS-1:0]      rsp_data_r;

   // Pair toggle, low-half holding register and burst response register.
   always_ff @(posedge K or negedge RST_b) begin
      if (!RST_b) begin
         pair_tog_r  <= 1'b0;
         lo_pair_r   <= {(BEATS_PER_PAIR*DATA_BITS){1'b0}};
         rsp_valid_r <= 1'b0;
         rsp_data_r  <= {(BURST_LEN*DATA_BITS){1'b0}};
      end else begin
         rsp_valid_r <= 1'b0;
         if (rd_pair_valid) begin
            if (!pair_tog_r) begin
               lo_pair_r  <= {rd_f, rd_r};
               pair_tog_r <= 1'b1;
            end else begin
               rsp_data_r  <= {rd_f, rd_r, lo_pair_r};
               rsp_valid_r <= 1'b1;
               pair_tog_r  <= 1'b0;
            end
         end
      end
   end

   assign rsp_valid = rsp_valid_r;
   assign rsp_data  = rsp_data_r;

endmodule

// File: rtl/ddr_cio_b4_ctrl.sv
// Command sequencer for a common-I/O burst-of-4 DDR SRAM: DLL start-up wait, command
// spacing, write-data pipeline, read-to-write turnaround and read burst reassembly.
module ddr_cio_b4_ctrl
   import ddr_cio_pkg::*;
#(
   parameter int ADDR_BITS    = 20,
   parameter int DATA_BITS    = 8,
   parameter int BWN          = 2,
   parameter int RD_LAT       = 2,
   parameter int TURN         = 1,
   parameter int DLL_LOCK_CYC = 1024
) (
   input  logic                 K,
   input  logic                 RST_b,
   ddr_cio_b4_ctrl_if.slave     host,
   output logic [ADDR_BITS-1:0] sram_sa,
   output logic                 sram_ld_b,
   output logic                 sram_rw_b,
   output logic [BWN-1:0]       sram_nw_b_r,
   output logic [BWN-1:0]       sram_nw_b_f,
   output logic [DATA_BITS-1:0] dq_r,
   output logic [DATA_BITS-1:0] dq_f,
   output logic                 dq_oe,
   input  logic                 rd_pair_valid,
   input  logic [DATA_BITS-1:0] rd_r,
   input  logic [DATA_BITS-1:0] rd_f,
   output logic                 sram_doff_b
);

   localparam int LOCK_W = $clog2(DLL_LOCK_CYC + 1);
   localparam int WBLK_W = $clog2(RD_LAT + TURN + 1);
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(DLL_LOCK_CYC - 1);
   localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);
   localparam logic [WBLK_W-1:0] WBLK_LOAD = WBLK_W'(RD_LAT + TURN);
   localparam logic [WBLK_W-1:0] WBLK_ONE  = WBLK_W'(1);
   localparam logic [WBLK_W-1:0] WBLK_ZERO = {WBLK_W{1'b0}};

   ctrl_state_e                    state_r, state_nxt_s;
   logic [LOCK_W-1:0]              lock_cnt_r;
   logic [WBLK_W-1:0]              wblk_r;
   logic                           ready_s, accept_s;
   logic                           doff_r;
   logic                           ld_b_r, rw_b_r;
   logic [ADDR_BITS-1:0]           sa_r;
   logic [BURST_LEN*DATA_BITS-1:0] wr_data_r;
   logic [BURST_LEN*BWN-1:0]       wr_nw_r;
   logic                           wr_ph1_r, wr_ph2_r;
   logic [DATA_BITS-1:0]           dq_rise_r, dq_fall_r;
   logic [BWN-1:0]                 nw_rise_r, nw_fall_r;
   logic                           oe_r;
   logic                           rsp_valid_s;
   logic [BURST_LEN*DATA_BITS-1:0] rsp_data_s;

   // State register and DLL lock counter.
   always_ff @(posedge K or negedge RST_b) begin
      if (!RST_b) begin
         state_r    <= ST_INIT;
         lock_cnt_r <= {LOCK_W{1'b0}};
         doff_r     <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         doff_r  <= 1'b1;
         if (state_r == ST_INIT) begin
            lock_cnt_r <= lock_cnt_r + LOCK_ONE;
         end
      end
   end

   // Next state, host ready and accept; writes wait out the read turnaround, reads never do.
   always_comb begin
      state_nxt_s = state_r;
      ready_s     = 1'b0;
      accept_s    = 1'b0;
      case (state_r)
         ST_INIT: begin
            if (lock_cnt_r == LOCK_LAST) state_nxt_s = ST_IDLE;
            else                         state_nxt_s = ST_INIT;
         end
         ST_IDLE: begin
            ready_s  = host.req_rd | (wblk_r == WBLK_ZERO);
            accept_s = ready_s & host.req_valid;
            if (accept_s) state_nxt_s = ST_GAP;
            else          state_nxt_s = ST_IDLE;
         end
         ST_GAP: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_INIT;
         end
      endcase
   end

   // Turnaround counter: holds through the read command cycle, then counts down in IDLE.
   always_ff @(posedge K or negedge RST_b) begin
      if (!RST_b) begin
         wblk_r <= WBLK_ZERO;
      end else if (accept_s && host.req_rd) begin
         wblk_r <= WBLK_LOAD;
      end else if ((state_r == ST_IDLE) && (wblk_r != WBLK_ZERO)) begin
         wblk_r <= wblk_r - WBLK_ONE;
      end
   end

   // Command bus registers: LD_b low for exactly the cycle after accept; SA/RW_b hold otherwise.
   always_ff @(posedge K or negedge RST_b) begin
      if (!RST_b) begin
         ld_b_r <= 1'b1;
         rw_b_r <= 1'b1;
         sa_r   <= {ADDR_BITS{1'b0}};
      end else begin
         ld_b_r <= ~accept_s;
         if (accept_s) begin
            rw_b_r <= host.req_rd;
            sa_r   <= host.req_addr;
         end
      end
   end

   // Write burst capture and two-phase marker feeding the data cycles after the command.
   always_ff @(posedge K or negedge RST_b) begin
      if (!RST_b) begin
         wr_data_r <= {(BURST_LEN*DATA_BITS){1'b0}};
         wr_nw_r   <= {(BURST_LEN*BWN){1'b1}};
         wr_ph1_r  <= 1'b0;
         wr_ph2_r  <= 1'b0;
      end else begin
         wr_ph1_r <= accept_s & ~host.req_rd;
         wr_ph2_r <= wr_ph1_r;
         if (accept_s && !host.req_rd) begin
            wr_data_r <= host.req_wdata;
            wr_nw_r   <= host.req_nw_b;
         end
      end
   end

   // DQ drive: beats 0/1 then 2/3; a new write's capture never clobbers beats 2/3 in flight.
   always_ff @(posedge K or negedge RST_b) begin
      if (!RST_b) begin
         dq_rise_r <= {DATA_BITS{1'b0}};
         dq_fall_r <= {DATA_BITS{1'b0}};
         nw_rise_r <= {BWN{1'b1}};
         nw_fall_r <= {BWN{1'b1}};
         oe_r      <= 1'b0;
      end else if (wr_ph1_r) begin
         dq_rise_r <= wr_data_r[beat_lsb(0, DATA_BITS) +: DATA_BITS];
         dq_fall_r <= wr_data_r[beat_lsb(1, DATA_BITS) +: DATA_BITS];
         nw_rise_r <= wr_nw_r[beat_lsb(0, BWN) +: BWN];
         nw_fall_r <= wr_nw_r[beat_lsb(1, BWN) +: BWN];
         oe_r      <= 1'b1;
      end else if (wr_ph2_r) begin
         dq_rise_r <= wr_data_r[beat_lsb(2, DATA_BITS) +: DATA_BITS];
         dq_fall_r <= wr_data_r[beat_lsb(3, DATA_BITS) +: DATA_BITS];
         nw_rise_r <= wr_nw_r[beat_lsb(2, BWN) +: BWN];
         nw_fall_r <= wr_nw_r[beat_lsb(3, BWN) +: BWN];
         oe_r      <= 1'b1;
      end else begin
         dq_rise_r <= {DATA_BITS{1'b0}};
         dq_fall_r <= {DATA_BITS{1'b0}};
         nw_rise_r <= {BWN{1'b1}};
         nw_fall_r <= {BWN{1'b1}};
         oe_r      <= 1'b0;
      end
   end

   ddr_cio_rd_asm #(.DATA_BITS(DATA_BITS)) u_rd_asm (
      .K             (K),
      .RST_b         (RST_b),
      .rd_pair_valid (rd_pair_valid),
      .rd_r          (rd_r),
      .rd_f          (rd_f),
      .rsp_valid     (rsp_valid_s),
      .rsp_data      (rsp_data_s)
   );

   assign host.req_ready = ready_s;
   assign host.rsp_valid = rsp_valid_s;
   assign host.rsp_data  = rsp_data_s;
   assign sram_sa        = sa_r;
   assign sram_ld_b      = ld_b_r;
   assign sram_rw_b      = rw_b_r;
   assign sram_nw_b_r    = nw_rise_r;
   assign sram_nw_b_f    = nw_fall_r;
   assign dq_r           = dq_rise_r;
   assign dq_f           = dq_fall_r;
   assign dq_oe          = oe_r;
   assign sram_doff_b    = doff_r;

endmodule

// File: tb/tb_ddr_cio_b4_ctrl.sv
// Bench for ddr_cio_b4_ctrl: a cycle-indexed timeline model built from the command timing
// rules, checked every cycle, plus directed cases pinned with literal expectations.
module tb_ddr_cio_b4_ctrl;
   localparam int AB = 20, DB = 8, NB = 2, LOCK = 16, RDL = 2, TRN = 1, MAXC = 1024;

   logic K = 1'b0, RST_b = 1'b0;
   logic [AB-1:0] sram_sa;
   logic sram_ld_b, sram_rw_b, dq_oe, sram_doff_b, rd_pair_valid;
   logic [NB-1:0] sram_nw_b_r, sram_nw_b_f;
   logic [DB-1:0] dq_r, dq_f, rd_r, rd_f;

   always #5 K = ~K;

   ddr_cio_b4_ctrl_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .BWN(NB)) host_if ();

   ddr_cio_b4_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB), .BWN(NB), .RD_LAT(RDL), .TURN(TRN),
                     .DLL_LOCK_CYC(LOCK)) dut (
      .K(K), .RST_b(RST_b), .host(host_if.slave), .sram_sa(sram_sa), .sram_ld_b(sram_ld_b),
      .sram_rw_b(sram_rw_b), .sram_nw_b_r(sram_nw_b_r), .sram_nw_b_f(sram_nw_b_f),
      .dq_r(dq_r), .dq_f(dq_f), .dq_oe(dq_oe), .rd_pair_valid(rd_pair_valid),
      .rd_r(rd_r), .rd_f(rd_f), .sram_doff_b(sram_doff_b));

   int errors = 0, checks = 0, cyc = 0;
   // Timeline model: what must be on the pins in each cycle after reset release.
   bit            m_cmd [MAXC];
   bit            m_cmd_rd [MAXC];
   logic [AB-1:0] m_cmd_addr [MAXC];
   bit            m_oe [MAXC];
   logic [DB-1:0] m_dqr [MAXC], m_dqf [MAXC];
   logic [NB-1:0] m_nwr [MAXC], m_nwf [MAXC];
   bit            m_rsp [MAXC];
   logic [31:0]   m_rsp_d [MAXC];
   bit            p_v [MAXC];
   logic [DB-1:0] p_r [MAXC], p_f [MAXC];
   int            last_cmd, last_rd;
   bit            m_tog, cur_rw;
   logic [15:0]   m_lo;
   logic [AB-1:0] cur_sa;
   logic [31:0]   pair_data;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < MAXC; i++) begin
         m_cmd[i] = 1'b0; m_oe[i] = 1'b0; m_rsp[i] = 1'b0; p_v[i] = 1'b0;
      end
      last_cmd = -100; last_rd = -100; m_tog = 1'b0; cur_rw = 1'b1; cur_sa = '0; cyc = 0;
   endtask

   // One cycle: compare pins with the model, drive inputs, check ready, extend the timeline.
   task automatic step(input bit v, input bit rd, input logic [AB-1:0] addr,
                       input logic [31:0] wd, input logic [7:0] nw, output bit acc);
      bit rdy;
      int c, n;
      @(negedge K);
      cyc++;
      c = cyc;
      if (c >= MAXC - 8) begin
         errors++;
         $display("FAIL cycle_budget: cycle %0d exceeds timeline %0d", c, MAXC - 8);
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $fatal(1, "timeline exhausted");
      end
      if (m_cmd[c]) begin cur_sa = m_cmd_addr[c]; cur_rw = m_cmd_rd[c]; end
      check("ld_b", sram_ld_b, !m_cmd[c]);
      check("rw_b", sram_rw_b, cur_rw);
      check("sa", sram_sa, cur_sa);
      check("dq_oe", dq_oe, m_oe[c]);
      if (m_oe[c]) begin
         check("dq_r", dq_r, m_dqr[c]);
         check("dq_f", dq_f, m_dqf[c]);
         check("nw_b_r", sram_nw_b_r, m_nwr[c]);
         check("nw_b_f", sram_nw_b_f, m_nwf[c]);
      end
      check("rsp_valid", host_if.rsp_valid, m_rsp[c]);
      if (m_rsp[c]) check("rsp_data", host_if.rsp_data, m_rsp_d[c]);
      check("doff_b", sram_doff_b, 1'b1);

      host_if.req_valid = v; host_if.req_rd = rd; host_if.req_addr = addr;
      host_if.req_wdata = wd; host_if.req_nw_b = nw;
      rd_pair_valid = p_v[c]; rd_r = p_r[c]; rd_f = p_f[c];
      #1;
      rdy = (c >= LOCK) && (c >= last_cmd + 1) && (rd || (c + 1 >= last_rd + RDL + TRN + 2));
      check("req_ready", host_if.req_ready, rdy);
      acc = v && rdy;
      if (acc) begin
         n = c + 1;
         m_cmd[n] = 1'b1; m_cmd_rd[n] = rd; m_cmd_addr[n] = addr; last_cmd = n;
         if (rd) begin
            last_rd = n;
            p_v[n+RDL] = 1'b1;   p_r[n+RDL] = pair_data[7:0];    p_f[n+RDL] = pair_data[15:8];
            p_v[n+RDL+1] = 1'b1; p_r[n+RDL+1] = pair_data[23:16]; p_f[n+RDL+1] = pair_data[31:24];
         end else begin
            m_oe[n+1] = 1'b1; m_dqr[n+1] = wd[7:0];   m_dqf[n+1] = wd[15:8];
            m_nwr[n+1] = nw[1:0]; m_nwf[n+1] = nw[3:2];
            m_oe[n+2] = 1'b1; m_dqr[n+2] = wd[23:16]; m_dqf[n+2] = wd[31:24];
            m_nwr[n+2] = nw[5:4]; m_nwf[n+2] = nw[7:6];
         end
      end
      if (p_v[c]) begin
         if (!m_tog) begin
            m_lo = {p_f[c], p_r[c]}; m_tog = 1'b1;
         end else begin
            m_rsp[c+1] = 1'b1; m_rsp_d[c+1] = {p_f[c], p_r[c], m_lo}; m_tog = 1'b0;
         end
      end
   endtask

   task automatic idle();
      bit acc;
      step(1'b0, 1'b0, '0, '0, 8'hFF, acc);
   endtask

   // Holds the request until accepted; returns the command cycle.
   task automatic step_req(input bit rd, input logic [AB-1:0] addr, input logic [31:0] wd,
                           input logic [7:0] nw, output int n);
      bit acc;
      n = -1;
      for (int i = 0; i < 40 && n < 0; i++) begin
         step(1'b1, rd, addr, wd, nw, acc);
         if (acc) n = cyc + 1;
      end
      if (n < 0) begin
         checks++; errors++;
         $display("FAIL req_timeout: request not accepted within 40 cycles");
      end
   endtask

   task automatic release_and_lock();
      @(negedge K);
      #2 RST_b = 1'b1;
      model_clear();
      #1 check("doff_before_first_rise", sram_doff_b, 1'b0);
      for (int i = 0; i < LOCK - 1; i++) idle();
      check("ready_still_locking", host_if.req_ready, 1'b0);
      idle();
      check("ready_after_lock", host_if.req_ready, 1'b1);
   endtask

   task automatic do_reset();
      RST_b = 1'b0;
      #1;
      check("rst_dq_oe", dq_oe, 1'b0);
      check("rst_ld_b", sram_ld_b, 1'b1);
      check("rst_doff_b", sram_doff_b, 1'b0);
      check("rst_rsp_valid", host_if.rsp_valid, 1'b0);
      check("rst_ready", host_if.req_ready, 1'b0);
      host_if.req_valid = 1'b0; rd_pair_valid = 1'b0;
      repeat (2) @(negedge K);
      release_and_lock();
   endtask

   initial begin
      int n, r, w, r2;
      bit acc, pend, prd;
      logic [AB-1:0] paddr;
      logic [31:0] pwd;
      logic [7:0] pnw;
      host_if.req_valid = 1'b0; host_if.req_rd = 1'b0; host_if.req_addr = '0;
      host_if.req_wdata = '0; host_if.req_nw_b = 8'hFF;
      rd_pair_valid = 1'b0; rd_r = '0; rd_f = '0;
      pair_data = 32'h0;
      model_clear();
      repeat (3) @(negedge K);
      check("rst_val_ld_b", sram_ld_b, 1'b1);
      check("rst_val_rw_b", sram_rw_b, 1'b1);
      check("rst_val_nw", {sram_nw_b_r, sram_nw_b_f}, 4'hF);
      check("rst_val_dq", {dq_r, dq_f, dq_oe}, 17'h0);
      check("rst_val_sa", sram_sa, 20'h0);
      check("rst_val_rsp", {host_if.rsp_valid, host_if.rsp_data}, 33'h0);
      check("rst_val_doff", sram_doff_b, 1'b0);
      check("rst_val_ready", host_if.req_ready, 1'b0);
      release_and_lock();

      // Full write burst.
      step_req(1'b0, 20'h11111, 32'h44332211, 8'h00, n);
      idle();
      check("wr_cmd_ld_rw", {sram_ld_b, sram_rw_b}, 2'b00);
      check("wr_cmd_sa", sram_sa, 20'h11111);
      check("wr_cmd_oe", dq_oe, 1'b0);
      idle();
      check("wr_pair0", {dq_oe, dq_r, dq_f}, 17'h1_1122);
      idle();
      check("wr_pair1", {dq_oe, dq_r, dq_f}, 17'h1_3344);
      idle();
      check("wr_after_oe", dq_oe, 1'b0);

      // Read burst reassembled from two injected pairs.
      pair_data = 32'h44332211;
      step_req(1'b1, 20'h11111, 32'h0, 8'hFF, r);
      repeat (4) idle();
      check("rd_rsp_early", host_if.rsp_valid, 1'b0);
      idle();
      check("rd_rsp_valid", host_if.rsp_valid, 1'b1);
      check("rd_rsp_data", host_if.rsp_data, 32'h44332211);

      // Turnaround: write blocked after a read, read follows a write at minimum spacing.
      pair_data = $urandom;
      step_req(1'b1, 20'h0ABCD, 32'h0, 8'hFF, r);
      step_req(1'b0, 20'h0F00F, 32'hDEADBEEF, 8'h00, w);
      check("wr_after_rd_cycle", w - r, RDL + TRN + 2);
      pair_data = $urandom;
      step_req(1'b1, 20'h12345, 32'h0, 8'hFF, r2);
      check("rd_after_wr_cycle", r2 - w, 2);

      // Per-beat byte-write enables 2,1,2,1.
      step_req(1'b0, 20'h00777, 32'hA5A5_5A5A, 8'h66, n);
      repeat (2) idle();
      check("nw_pair0", {sram_nw_b_r, sram_nw_b_f}, 4'b10_01);
      idle();
      check("nw_pair1", {sram_nw_b_r, sram_nw_b_f}, 4'b10_01);
      repeat (6) idle();

      // Reset in the first data cycle of a write.
      step_req(1'b0, 20'h22222, 32'h0BADF00D, 8'h00, n);
      repeat (2) idle();
      check("mid_burst_oe", dq_oe, 1'b1);
      do_reset();

      // Reset between the two pairs of a read: the partial burst must vanish.
      pair_data = 32'h87654321;
      step_req(1'b1, 20'h33333, 32'h0, 8'hFF, r);
      repeat (4) idle();
      do_reset();

      // Randomised traffic with held requests.
      pend = 1'b0; prd = 1'b0; paddr = '0; pwd = '0; pnw = 8'hFF;
      for (int i = 0; i < 500; i++) begin
         if (!pend && ($urandom_range(0, 3) != 0)) begin
            pend = 1'b1; prd = 1'($urandom_range(0, 1));
            paddr = AB'($urandom); pwd = $urandom; pnw = 8'($urandom);
            pair_data = $urandom;
         end
         step(pend, prd, paddr, pwd, pnw, acc);
         if (acc) pend = 1'b0;
      end
      repeat (8) idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
